// File: rtl/frogger_game_if.sv
// Signal bundle between the Frogger datapath (collision logic, frog, cars, logs)
// and the game-flow sequencer. The sequencer uses the slave modport.
interface frogger_game_if #(
    parameter int SCORE_W = 14
);
    logic               frame_tick;
    logic               collision;
    logic               reached_end;
    logic [3:0]         dpad_input;
    logic [9:0]         frog_y;
    logic [1:0]         frog_state;
    logic [2:0]         game_state;
    logic               frog_respawn;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [2:0]         level;

    modport master (
        output frame_tick, collision, reached_end, dpad_input, frog_y,
        input  frog_state, game_state, frog_respawn, lives, score, level
    );

    modport slave (
        input  frame_tick, collision, reached_end, dpad_input, frog_y,
        output frog_state, game_state, frog_respawn, lives, score, level
    );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game-flow sequencer: lives, score, level and frog freeze/respawn control.
// Optional build macro FROGGER_BONUS_LIFE_EN: every level-up also grants a life (max 7).
module frogger_game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 90,
    parameter int SCORE_W      = 14,
    parameter int HOP_POINTS   = 10,
    parameter int HOME_POINTS  = 50,
    parameter int INIT_Y       = 448
) (
    input  logic           clk,
    input  logic           reset_n,
    frogger_game_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        DYING    = 3'd2,
        LEVELUP  = 3'd3,
        GAMEOVER = 3'd4
    } game_state_e;

    localparam logic [2:0] LIVES_MAX  = 3'd7;
    localparam logic [2:0] LEVEL_MAX  = 3'd7;
    localparam logic [9:0] SPAWN_Y    = 10'(INIT_Y);
    // Counter holds ticks already seen, so expiry is on the tick that makes it the limit.
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input int unsigned         pts);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W + 1)'(pts);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // D-pad synchronizer and rising-edge detect
    logic [3:0] dpad_s1, dpad_s2, dpad_s3;
    logic       start;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dpad_s1 <= '0;
            dpad_s2 <= '0;
            dpad_s3 <= '0;
        end else begin
            dpad_s1 <= bus.dpad_input;
            dpad_s2 <= dpad_s1;
            dpad_s3 <= dpad_s2;
        end
    end

    assign start = |(dpad_s2 & ~dpad_s3);

    game_state_e        state_q, state_d;
    logic [1:0]         frog_state_q, frog_state_d;
    logic               respawn_q, respawn_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         level_q, level_d;
    logic [9:0]         best_y_q, best_y_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            frog_state_q <= 2'b00;
            respawn_q    <= 1'b0;
            lives_q      <= '0;
            score_q      <= '0;
            level_q      <= '0;
            best_y_q     <= SPAWN_Y;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            frog_state_q <= frog_state_d;
            respawn_q    <= respawn_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            level_q      <= level_d;
            best_y_q     <= best_y_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that skipped one
    // would infer a latch instead of combinational logic.
    always_comb begin
        state_d     = state_q;
        respawn_d   = 1'b0;
        lives_d     = lives_q;
        score_d     = score_q;
        level_d     = level_q;
        best_y_d    = best_y_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE, GAMEOVER: begin
                if (start) begin
                    lives_d   = 3'(LIVES_INIT);
                    score_d   = '0;
                    level_d   = '0;
                    best_y_d  = SPAWN_Y;
                    respawn_d = 1'b1;
                    state_d   = PLAY;
                end
            end
            PLAY: begin
                if (bus.collision) begin
                    state_d = DYING;
                    if (lives_q != '0) lives_d = lives_q - 3'd1;
                end else if (bus.reached_end) begin
                    state_d = LEVELUP;
                    score_d = sat_add(score_q, HOME_POINTS);
                    if (level_q != LEVEL_MAX) level_d = level_q + 3'd1;
`ifdef FROGGER_BONUS_LIFE_EN
                    if (lives_q != LIVES_MAX) lives_d = lives_q + 3'd1;
`else
                    lives_d = lives_q;
`endif
                end else if (bus.frog_y < best_y_q) begin
                    score_d  = sat_add(score_q, HOP_POINTS);
                    best_y_d = bus.frog_y;
                end
            end
            DYING: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == DEATH_LAST) begin
                        if (lives_q == '0) begin
                            state_d = GAMEOVER;
                        end else begin
                            state_d   = PLAY;
                            respawn_d = 1'b1;
                            best_y_d  = SPAWN_Y;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            LEVELUP: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == WIN_LAST) begin
                        state_d   = PLAY;
                        respawn_d = 1'b1;
                        best_y_d  = SPAWN_Y;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any transition restarts the frame timer, even if a tick arrived this cycle.
        if (state_d != state_q) frame_cnt_d = '0;

        frog_state_d = (state_d == PLAY) ? 2'b01 : 2'b00;
    end

    assign bus.game_state   = state_q;
    assign bus.frog_state   = frog_state_q;
    assign bus.frog_respawn = respawn_q;
    assign bus.lives        = lives_q;
    assign bus.score        = score_q;
    assign bus.level        = level_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Scoreboard bench for frogger_game_ctrl: a rule-level game model predicts every
// cycle's outputs; a monitor pops and compares after each clock edge.
module tb_frogger_game_ctrl;

    localparam int SCORE_W      = 14;
    localparam int SAT_W        = 8;
    localparam int SAT_MAX      = 255;
    localparam int LIVES_INIT   = 3;
    localparam int DEATH_FRAMES = 60;
    localparam int WIN_FRAMES   = 90;
    localparam int HOP_POINTS   = 10;
    localparam int HOME_POINTS  = 50;
    localparam int INIT_Y       = 448;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_LEVELUP = 3, S_GAMEOVER = 4;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    frogger_game_if #(.SCORE_W(SCORE_W)) bus ();
    frogger_game_if #(.SCORE_W(SAT_W))   bus8 ();

    frogger_game_ctrl #(
        .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES),
        .SCORE_W(SCORE_W), .HOP_POINTS(HOP_POINTS), .HOME_POINTS(HOME_POINTS), .INIT_Y(INIT_Y)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Narrow-score copy sharing the same inputs, used to exercise score saturation.
    frogger_game_ctrl #(
        .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES),
        .SCORE_W(SAT_W), .HOP_POINTS(HOP_POINTS), .HOME_POINTS(HOME_POINTS), .INIT_Y(INIT_Y)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus8)
    );

    assign bus8.frame_tick  = bus.frame_tick;
    assign bus8.collision   = bus.collision;
    assign bus8.reached_end = bus.reached_end;
    assign bus8.dpad_input  = bus.dpad_input;
    assign bus8.frog_y      = bus.frog_y;

    typedef struct {
        int gs;
        int fs;
        int rsp;
        int lives;
        int score;
        int level;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (game rules) ----------------
    logic [3:0] hist[3];   // d-pad samples from 1, 2 and 3 edges ago
    int m_mode, m_lives, m_score, m_level, m_best, m_left;
    bit m_rsp;

    function automatic int add_pts(input int s, input int p);
        int lim;
        lim = (1 << SCORE_W) - 1;
        return (s + p > lim) ? lim : s + p;
    endfunction

    task automatic model_reset();
        m_mode = S_IDLE; m_lives = 0; m_score = 0; m_level = 0;
        m_best = INIT_Y; m_left = 0; m_rsp = 0;
        for (int i = 0; i < 3; i++) hist[i] = 4'b0;
    endtask

    task automatic model_step(input bit tick, input bit coll, input bit home,
                              input logic [3:0] dp, input int fy);
        bit start;
        start = |(hist[1] & ~hist[2]);
        m_rsp = 0;
        case (m_mode)
            S_IDLE, S_GAMEOVER: if (start) begin
                m_lives = LIVES_INIT; m_score = 0; m_level = 0; m_best = INIT_Y;
                m_rsp = 1; m_mode = S_PLAY;
            end
            S_PLAY: begin
                if (coll) begin
                    m_mode = S_DYING; m_left = DEATH_FRAMES;
                    if (m_lives > 0) m_lives--;
                end else if (home) begin
                    m_mode  = S_LEVELUP; m_left = WIN_FRAMES;
                    m_score = add_pts(m_score, HOME_POINTS);
                    m_level = (m_level < 7) ? m_level + 1 : 7;
`ifdef FROGGER_BONUS_LIFE_EN
                    m_lives = (m_lives < 7) ? m_lives + 1 : 7;
`endif
                end else if (fy < m_best) begin
                    m_score = add_pts(m_score, HOP_POINTS);
                    m_best  = fy;
                end
            end
            S_DYING: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) m_mode = S_GAMEOVER;
                    else begin m_mode = S_PLAY; m_rsp = 1; m_best = INIT_Y; end
                end
            end
            S_LEVELUP: if (tick) begin
                m_left--;
                if (m_left == 0) begin m_mode = S_PLAY; m_rsp = 1; m_best = INIT_Y; end
            end
            default: ;
        endcase
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = dp;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit tick, input bit coll, input bit home,
                         input logic [3:0] dp, input int fy);
        obs_t e;
        bus.frame_tick  = tick;
        bus.collision   = coll;
        bus.reached_end = home;
        bus.dpad_input  = dp;
        bus.frog_y      = 10'(fy);
        model_step(tick, coll, home, dp, fy);
        e.gs = m_mode; e.fs = (m_mode == S_PLAY) ? 1 : 0; e.rsp = m_rsp;
        e.lives = m_lives; e.score = m_score; e.level = m_level;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit tick, input bit coll, input bit home,
                        input logic [3:0] dp, input int fy);
        @(negedge clk);
        drive(tick, coll, home, dp, fy);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int mode, input int max_cyc, input int fy, input string what);
        int n;
        n = 0;
        while (m_mode != mode && n < max_cyc) begin
            step(1'($urandom % 2), 1'b0, 1'b0, 4'b0, fy);
            n++;
        end
        settle();
        check(what, bus.game_state, mode);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b0, INIT_Y);
    endtask

    task automatic press_start(input logic [3:0] btn);
        repeat (4) step(1'b0, 1'b0, 1'b0, btn, INIT_Y);
        run_until(S_PLAY, 10, INIT_Y, "start_to_play");
    endtask

    // ---------------- monitor ----------------
    obs_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check($sformatf("game_state(cyc %0d)", n_cyc), int'(bus.game_state), mon_e.gs);
                check($sformatf("frog_state(cyc %0d)", n_cyc), int'(bus.frog_state), mon_e.fs);
                check($sformatf("frog_respawn(cyc %0d)", n_cyc), int'(bus.frog_respawn), mon_e.rsp);
                check($sformatf("lives(cyc %0d)", n_cyc), int'(bus.lives), mon_e.lives);
                check($sformatf("score(cyc %0d)", n_cyc), int'(bus.score), mon_e.score);
                check($sformatf("level(cyc %0d)", n_cyc), int'(bus.level), mon_e.level);
                check($sformatf("score_sat8(cyc %0d)", n_cyc), int'(bus8.score),
                      (mon_e.score > SAT_MAX) ? SAT_MAX : mon_e.score);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int ys[5];
    int y, hold, r;
    logic [3:0] btn, dp;
    bit tk, cl, hm;

    initial begin
        reset_n = 1'b0;
        bus.frame_tick = 1'b0; bus.collision = 1'b0; bus.reached_end = 1'b0;
        bus.dpad_input = 4'b0; bus.frog_y = 10'(INIT_Y);
        model_reset();

        // Reset values while reset is held
        #23;
        check("rst_game_state", bus.game_state, S_IDLE);
        check("rst_frog_state", bus.frog_state, 0);
        check("rst_respawn", bus.frog_respawn, 0);
        check("rst_lives", bus.lives, 0);
        check("rst_score", bus.score, 0);
        check("rst_level", bus.level, 0);

        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b0, INIT_Y);

        // Start with 'up' held for 10 cycles
        repeat (10) step(1'b0, 1'b0, 1'b0, 4'b0100, INIT_Y);
        repeat (5) step(1'b0, 1'b0, 1'b0, 4'b0, INIT_Y);
        settle();
        check("start_game_state", bus.game_state, S_PLAY);
        check("start_lives", bus.lives, LIVES_INIT);
        check("start_frog_state", bus.frog_state, 1);

        // Advance, retreat, re-advance: only new furthest rows score
        ys[0] = 448; ys[1] = 416; ys[2] = 384; ys[3] = 416; ys[4] = 384;
        for (int i = 0; i < 5; i++)
            repeat (3) step(1'($urandom % 2), 1'b0, 1'b0, 4'b0, ys[i]);
        settle();
        check("hop_score", bus.score, 20);

        // Collision and home together, with a frame tick: collision wins
        step(1'b1, 1'b1, 1'b1, 4'b0, 384);
        settle();
        check("coll_prio_state", bus.game_state, S_DYING);
        check("coll_prio_lives", bus.lives, 2);
        check("coll_prio_score", bus.score, 20);
        check("coll_prio_level", bus.level, 0);
        run_until(S_PLAY, 400, INIT_Y, "dying_to_play");

        // Randomized play
        y = INIT_Y; hold = 0; btn = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            tk = (($urandom % 3) == 0);
            cl = (($urandom % 50) == 0);
            hm = (($urandom % 70) == 0);
            if (hold > 0) hold--;
            else if (($urandom % 40) == 0) begin
                hold = 2 + int'($urandom % 5);
                btn  = 4'(1 << ($urandom % 4));
            end
            dp = (hold > 0) ? btn : 4'b0;
            r = int'($urandom % 8);
            if (r < 2 && y >= 32) y -= 32;
            else if (r == 2 && y <= INIT_Y - 32) y += 32;
            step(tk, cl, hm, dp, y);
            if (m_rsp) y = INIT_Y;
        end

        // Three deaths from a fresh game end in GAMEOVER with score held
        do_reset();
        press_start(4'b0100);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 4'b0, 416);
            step(1'b0, 1'b1, 1'b0, 4'b0, 416);
            run_until((k < 2) ? S_PLAY : S_GAMEOVER, 400, INIT_Y, "death_timeout");
        end
        check("gameover_frog_state", bus.frog_state, 0);
        check("gameover_lives", bus.lives, 0);
        check("gameover_score", bus.score, 30);
        repeat (5) step(1'b1, 1'b1, 1'b1, 4'b0, 100);
        press_start(4'b1000);
        check("restart_score", bus.score, 0);
        check("restart_lives", bus.lives, LIVES_INIT);

        // Eight level-ups saturate the level
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 4'b0, INIT_Y);
            run_until(S_PLAY, 600, INIT_Y, "levelup_to_play");
        end
        check("level_sat", bus.level, 7);
        check("levels_score", bus.score, 400);
`ifdef FROGGER_BONUS_LIFE_EN
        check("levels_lives", bus.lives, 7);
`else
        check("levels_lives", bus.lives, LIVES_INIT);
`endif

        // Asynchronous reset in the middle of DYING
        step(1'b0, 1'b1, 1'b0, 4'b0, INIT_Y);
        repeat (5) step(1'b1, 1'b0, 1'b0, 4'b0, INIT_Y);
        settle();
        check("pre_reset_state", bus.game_state, S_DYING);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", bus.game_state, S_IDLE);
        check("async_rst_lives", bus.lives, 0);
        check("async_rst_score", bus.score, 0);
        check("async_rst_level", bus.level, 0);
        check("async_rst_frog_state", bus.frog_state, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game-flow sequencer for the Frogger datapath. Decides when the frog may move, and counts lives, score and level from the frog's per-cycle `collision`, `reached_end` and position signals. It drives the frog's `state` input, issues respawn pulses, and supplies the `level` used to scale car and log speeds. It sits in `top` between the collision logic and the frog, cars and logs instances, all on the 25.1 MHz pixel clock.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded at game start (1–7).
- `DEATH_FRAMES`, 60: frames spent in DYING before respawn.
- `WIN_FRAMES`, 90: frames spent in LEVELUP before respawn.
- `SCORE_W`, 14: score width.
- `HOP_POINTS`, 10: points per new furthest row reached.
- `HOME_POINTS`, 50: points per `reached_end`.
- `INIT_Y`, 448: frog spawn row, in pixels.

Ports:
- `clk` in 1: pixel clock (`osc_25_1M`).
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (VSYNC start).
- `collision` in 1: frog hit car, water or screen edge (level).
- `reached_end` in 1: frog in home row (level).
- `dpad_input` in 4: `{right, up, down, left}`, active-high.
- `frog_y` in 10: current frog top-left y.
- `frog_state` out 2: `01` lets the frog move, `00` freezes it.
- `game_state` out 3: IDLE=0, PLAY=1, DYING=2, LEVELUP=3, GAMEOVER=4.
- `frog_respawn` out 1: one-cycle pulse that returns the frog to spawn.
- `lives` out 3: remaining lives.
- `score` out `SCORE_W`: current score.
- `level` out 3: difficulty, 0–7.

## Operation
- All outputs are registered. Reset values:
  - `game_state`=IDLE, `frog_state`=00, `frog_respawn`=0.
  - `lives`=0, `score`=0, `level`=0.
  - `best_y`=`INIT_Y`, frame counter=0.
- `dpad_input` passes through a 2-flop synchronizer, then a rising-edge detector. `start` = any bit rising.
- IDLE and GAMEOVER, on `start`:
  - Load `lives`=`LIVES_INIT`, `score`=0, `level`=0, `best_y`=`INIT_Y`.
  - Pulse `frog_respawn`; go to PLAY.
  - GAMEOVER keeps `score` visible until `start`.
- PLAY (`frog_state`=01):
  - `collision`=1: go to DYING and `lives`−1. `collision` has priority over `reached_end` in the same cycle.
  - `reached_end`=1 and no collision: go to LEVELUP; `score` += `HOME_POINTS`; `level` += 1, saturating at 7.
  - Otherwise, if `frog_y` < `best_y`: `score` += `HOP_POINTS` and `best_y` ← `frog_y`, at most once per cycle.
- DYING (`frog_state`=00): count `frame_tick` up to `DEATH_FRAMES`, then:
  - `lives`=0: go to GAMEOVER with no respawn.
  - Otherwise: pulse `frog_respawn`, set `best_y`=`INIT_Y`, go to PLAY.
- LEVELUP (`frog_state`=00): count to `WIN_FRAMES`, then pulse `frog_respawn`, reset `best_y`, go to PLAY.
- Arithmetic rules:
  - `score` saturates at all-ones and never wraps.
  - `lives` decrements only from nonzero.
  - Frame counter is 8 bits and clears on every state entry.
- `collision` and `reached_end` are ignored outside PLAY. This covers stale collision while the frog is frozen over a car.

## Timing
- Input (`collision`, `reached_end`, `frog_y`) at edge N → `game_state`, `lives` and `score` updated after edge N. `frog_state` drops to 00 in the same update, one cycle of latency.
- `dpad_input` → `start` latency: 3 cycles (2 synchronizer flops plus the edge register).
- `frog_respawn` is high for exactly one cycle, the same cycle `game_state` becomes PLAY. The frog module must sample it before the next move.
- Timer expiry occurs on the edge where the counter equals the limit and `frame_tick`=1. So DYING lasts exactly `DEATH_FRAMES` ticks after entry.
- `reset_n` asserted mid-game: all outputs return to reset values immediately (async). Release is synchronized by the instantiating reset logic.
- `frame_tick` concurrent with an event: the event transition wins, and the counter starts from 0 in the new state.

## Configuration
- `FROGGER_BONUS_LIFE_EN` defined: each LEVELUP entry also increments `lives`, saturating at 7.
- `FROGGER_BONUS_LIFE_EN` undefined: `lives` never increases after game start.

## Test plan
- Reset, then press `up` for 10 cycles → 3 cycles after the edge: `game_state`=1, `lives`=3, `frog_respawn` one pulse, `frog_state`=01.
- In PLAY, step `frog_y` 448→416→384→416→384 → `score`=20. Retreating and re-advancing earns nothing.
- In PLAY, raise `collision` and `reached_end` in the same cycle → DYING, `lives`=2, `score` unchanged, `level` unchanged. After 60 `frame_tick`s: `frog_respawn` pulse, PLAY.
- Three collisions from `lives`=3 → after the third DYING timeout, GAMEOVER, no respawn, `frog_state`=00, `score` held. A `right` press restarts with `score`=0.
- Eight `reached_end` events → `level` saturates at 7, `score`=400 plus hop points.
  - With the macro defined, `lives` is 7.
  - Without it, `lives` stays 3.
- Assert `reset_n`=0 mid-DYING → `game_state`=0, `lives`=0, `score`=0 without waiting for a clock edge.
